// File: rtl/sig_restoring_divider_if.sv
// Operand/result handshake bundle for the significand divider.
// The master drives operands and out_ready; the slave (divider) drives in_ready and results.
interface sig_restoring_divider_if #(
  parameter int WIDTH = 25
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/sig_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; result WIDTH+1 cycles after accept (1 for /0).
// Accepts only in IDLE; result is held in DONE until out_ready, no operand queuing.
module sig_restoring_divider #(
  parameter int WIDTH = 25
) (
  input logic                  clk,
  input logic                  rst_n,
  sig_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] sreg_nxt;

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

  // rem < dvsr holds between iterations, so the trial's MSB is exactly the borrow.
  always_comb begin
    r_shift  = {rem, sreg[WIDTH-1]};
    trial    = r_shift - {1'b0, dvsr};
    q_bit    = ~trial[WIDTH];
    rem_nxt  = q_bit ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    sreg_nxt = {sreg[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = (bus.divisor == '0) ? DONE : RUN;
      RUN:     if (cnt == '0)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      dvsr   <= '0;
      rem    <= '0;
      cnt    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.divisor != '0) begin
              sreg <= bus.dividend;
              dvsr <= bus.divisor;
              rem  <= '0;
              cnt  <= CW'(WIDTH - 1);
            end else begin
              quot_q <= '1;
              rem_q  <= bus.dividend;
              dbz_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          sreg <= sreg_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            quot_q <= sreg_nxt;
            rem_q  <= rem_nxt;
            dbz_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sig_restoring_divider.sv
// Scoreboard bench for sig_restoring_divider: directed, backpressure, reset-abort and random cases.
module tb_sig_restoring_divider;
  localparam int W = 25;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  sig_restoring_divider_if #(.WIDTH(W)) bus ();

  sig_restoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    e.q   = (b == '0) ? '1 : a / b;
    e.r   = (b == '0) ? a : a % b;
    e.dbz = (b == '0);
    sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Called directly after start_op: n=1 counts the accept edge itself.
  task automatic finish_op(input string name, input int exp_lat, input int stall);
    exp_t e;
    int   n = 1;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    if (exp_lat > 0) begin
      checks++;
      if (n !== exp_lat || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_latency: got %0d edges (out_valid=%b) required %0d", name, n, bus.out_valid, exp_lat);
      end
    end
    repeat (stall) tick();
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
      errors++;
      $display("FAIL %s_result: valid=%b q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
               name, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b q=%h r=%h dbz=%b required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    start_op(25'd100, 25'd7);
    finish_op("basic_100_7", W + 1, 0);
  endtask

  task automatic test_extremes();
    logic [W-1:0] ones;
    ones = '1;
    start_op(ones, 25'd1);     finish_op("max_div_1", W + 1, 0);
    start_op(ones, ones);      finish_op("max_div_max", W + 1, 0);
    start_op(25'd5, 25'd9);    finish_op("5_div_9", W + 1, 0);
    start_op(25'd0, 25'd3);    finish_op("0_div_3", W + 1, 0);
  endtask

  task automatic test_div_zero();
    start_op(25'd1234, 25'd0);
    finish_op("div_zero", 1, 0);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] q0, r0;
    bit           bad = 0;
    start_op(25'd500, 25'd3);
    while (!bus.out_valid) tick();
    q0 = bus.quotient;
    r0 = bus.remainder;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.dividend = 25'(i * 77);
      bus.divisor  = 25'(i);
      tick();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== q0 || bus.remainder !== r0) bad = 1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad || q0 !== 25'd166 || r0 !== 25'd2) begin
      errors++;
      $display("FAIL stall_hold: q=%h r=%h vld=%b rdy=%b required q=0a6 r=2 held with vld=1 rdy=0",
               bus.quotient, bus.remainder, bus.out_valid, bus.in_ready);
    end
    void'(sb.pop_front());
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: rdy=%b vld=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    start_op(25'd1000, 25'd10);
    finish_op("back_to_back", W + 1, 0);
  endtask

  task automatic test_reset_mid();
    bit stray = 0;
    start_op(25'd100, 25'd7);
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_abort: rdy=%b vld=%b q=%h r=%h dbz=%b required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    sb.delete();
    tick();
    rst_n = 1'b1;
    repeat (30) begin
      tick();
      if (bus.out_valid !== 1'b0) stray = 1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL abort_no_result: out_valid rose after aborted op, required 0");
    end
    start_op(25'd81, 25'd9);
    finish_op("after_reset", W + 1, 0);
  endtask

  task automatic test_random();
    logic [31:0]  ra, rb;
    logic [W-1:0] a, b;
    longint       recon;
    int           bad = 0;
    for (int i = 0; i < 2000; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(7, 31);
      a  = ra[W-1:0];
      b  = rb[W-1:0];
      if (b == '0) b = 25'd1;
      start_op(a, b);
      finish_op("random", W + 1, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0);
      recon = longint'(bus.quotient) * longint'(b) + longint'(bus.remainder);
      checks++;
      if (recon !== longint'(a) || bus.remainder >= b) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random_identity: a=%h b=%h q=%h r=%h gives %h required %h with r<b",
                   a, b, bus.quotient, bus.remainder, recon, a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end
endmodule
